// File: rtl/seq_detect_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_sched_if
// Purpose  : Job request / result handshake bundle for seq_detect_sched.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_detect_sched_if #(
  parameter int MAX_PAIRS = 12,
  parameter int CNT_W     = 4,
  parameter int HIT_W     = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [2*MAX_PAIRS-1:0] in_word;
  logic [CNT_W-1:0]       in_pairs;
  logic                   out_valid;
  logic                   out_ready;
  logic [HIT_W-1:0]       out_hits;
  logic [CNT_W-1:0]       out_first;

  modport master (
    output in_valid, in_word, in_pairs, out_ready,
    input  in_ready, out_valid, out_hits, out_first
  );

  modport slave (
    input  in_valid, in_word, in_pairs, out_ready,
    output in_ready, out_valid, out_hits, out_first
  );
endinterface
`default_nettype wire

// File: rtl/seq_detect_sched.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_sched
// Purpose  : Streams a pattern word into a serial A/B sequence detector and
//            reports the Z hit count and the index of the first hit.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_sched #(
  parameter int MAX_PAIRS = 12,
  parameter int CNT_W     = 4,
  parameter int HIT_W     = 4,
  parameter int Z_LAT     = 1
) (
  input  logic               clk,
  input  logic               clr,
  seq_detect_sched_if.slave  bus,
  output logic               det_clr_n,
  output logic               det_a,
  output logic               det_b,
  input  logic               det_z
);

  localparam int               c_ww  = 2 * MAX_PAIRS;
  localparam logic [CNT_W-1:0] c_max = CNT_W'(MAX_PAIRS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_det_clr_n;
  logic               r_det_a;
  logic               r_det_b;
  logic [HIT_W-1:0]   r_hits;
  logic [CNT_W-1:0]   r_first;
  logic [c_ww-1:0]    r_sh;
  logic [CNT_W-1:0]   r_rem;
  logic [CNT_W-1:0]   r_idx;
  logic [Z_LAT-1:0]   r_pv;
  logic [CNT_W-1:0]   r_pi [Z_LAT];

  logic [CNT_W-1:0]   w_n;
  logic [c_ww-1:0]    w_aligned;
  logic               w_push;
  logic               w_drained;

  assign w_n       = (bus.in_pairs > c_max) ? c_max : bus.in_pairs;
  // Left-align so the pair to send next is always the top two bits.
  assign w_aligned = bus.in_word << (2 * (MAX_PAIRS - int'(w_n)));
  assign w_push    = (r_state == S_STREAM);
  // Empty once the tag now sitting at the pipeline output retires.
  assign w_drained = (Z_LAT'(r_pv << 1) == '0);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_det_clr_n <= 1'b1;
      r_det_a     <= 1'b0;
      r_det_b     <= 1'b0;
      r_hits      <= '0;
      r_first     <= '1;
      r_sh        <= '0;
      r_rem       <= '0;
      r_idx       <= '0;
      r_pv        <= '0;
      for (int j = 0; j < Z_LAT; j++) r_pi[j] <= '0;
    end else begin
      r_pv    <= Z_LAT'(r_pv << 1) | Z_LAT'(w_push);
      r_pi[0] <= r_idx;
      for (int j = 1; j < Z_LAT; j++) r_pi[j] <= r_pi[j-1];

      if (r_pv[Z_LAT-1] && det_z) begin
        if (r_hits != '1) r_hits <= r_hits + 1'b1;
        if (r_first == '1) r_first <= r_pi[Z_LAT-1];
      end

      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_in_ready <= 1'b0;
            r_sh       <= w_aligned;
            r_rem      <= w_n;
            if (w_n == '0) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_hits      <= '0;
              r_first     <= '1;
            end else begin
              r_state     <= S_CLEAR;
              r_det_clr_n <= 1'b0;
            end
          end
        end
        S_CLEAR: begin
          r_det_clr_n <= 1'b1;
          r_hits      <= '0;
          r_first     <= '1;
          r_det_a     <= r_sh[c_ww-1];
          r_det_b     <= r_sh[c_ww-2];
          r_sh        <= r_sh << 2;
          r_rem       <= r_rem - 1'b1;
          r_idx       <= '0;
          r_state     <= S_STREAM;
        end
        S_STREAM: begin
          if (r_rem == '0) begin
            r_det_a <= 1'b0;
            r_det_b <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_det_a <= r_sh[c_ww-1];
            r_det_b <= r_sh[c_ww-2];
            r_sh    <= r_sh << 2;
            r_rem   <= r_rem - 1'b1;
            r_idx   <= r_idx + 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_drained) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_hits  = r_hits;
  assign bus.out_first = r_first;
  assign det_clr_n     = r_det_clr_n;
  assign det_a         = r_det_a;
  assign det_b         = r_det_b;

endmodule
`default_nettype wire

// File: doc/seq_detect_sched.md
Name: seq_detect_sched

Overview:
- Job sequencer for the serial two-input sequence detector (inputs A/B, output Z).
- Accepts a parallel pattern word plus a pair count over a valid/ready handshake, and pulses the detector's active-low clear.
- Streams the word to the detector one {A,B} pair per clock, MSB pair first, and counts Z assertions within a latency-aligned window.
- Returns the hit count and the index of the first hit over a second valid/ready handshake. Sits between a host/test driver and one detector instance.

Parameters:
- MAX_PAIRS, 12, maximum pairs per job; pattern word width is 2*MAX_PAIRS.
- CNT_W, 4, width of the pair-count and index fields; must hold MAX_PAIRS.
- HIT_W, 4, hit counter width; the counter saturates.
- Z_LAT, 1, cycles from a pair driven on det_a/det_b to its Z response on det_z; legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  asynchronous active-high reset.
- in_valid  in  1  job request.
- in_ready  out  1  scheduler can accept a job.
- in_word  in  2*MAX_PAIRS  pattern, right-aligned; pair k = in_word[2k+1:2k], where [2k+1] drives A and [2k] drives B.
- in_pairs  in  CNT_W  number of pairs to stream.
- det_clr_n  out  1  detector clear, active-low.
- det_a  out  1  A input of the detector.
- det_b  out  1  B input of the detector.
- det_z  in  1  detector Z output.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed.
- out_hits  out  HIT_W  Z=1 count within the window, saturating at all-ones.
- out_first  out  CNT_W  stream index (0 = first pair sent) whose Z hit first; all-ones if no hit.

Behaviour:
- All outputs registered.
- Reset state: state=IDLE, in_ready=1, det_clr_n=1, det_a=0, det_b=0, out_valid=0, out_hits=0, out_first=all-ones, all internal counters and the pipeline cleared.
- IDLE: in_ready=1. On in_valid&in_ready (cycle 0), latch in_word and the effective count N = min(in_pairs, MAX_PAIRS).
  - If N=0, go to DONE in cycle 1 with hits=0 and first=all-ones.
  - Otherwise go to CLEAR.
- CLEAR (cycle 1): det_clr_n=0 for exactly one cycle. Hit count zeroed, first=all-ones. Go to STREAM.
- STREAM (cycles 2..N+1): each cycle drive the next pair, starting at k=N-1 and descending to k=0. Push a valid tag plus the stream index (0..N-1) into a Z_LAT-deep shift pipeline. After pair k=0, go to DRAIN.
- DRAIN (cycles N+2..N+1+Z_LAT): det_a=det_b=0; push invalid tags into the pipeline. Exit when the pipeline is empty.
- Counting: in any cycle where the pipeline output tag is valid and det_z=1:
  - hits increments, saturating at all-ones;
  - if first is still all-ones, it loads the tagged index.
  - det_z is ignored when the tag is invalid, including IDLE, CLEAR and DONE.
- DONE (from cycle N+2+Z_LAT): out_valid=1, with out_hits and out_first stable. in_ready=0.
  - On out_valid&out_ready, go to IDLE next cycle and deassert out_valid. The result registers hold their last values.
- in_ready=0 in every state except IDLE. New requests are never accepted while a result is pending.
- Backpressure: out_ready low holds DONE indefinitely. Results are never dropped or overwritten.
- det_a/det_b are 0 outside STREAM. det_clr_n is 1 outside CLEAR.
- clr asserted in any state forces the reset state immediately. Any partial job is discarded and produces no result.
- in_pairs > MAX_PAIRS is clamped to MAX_PAIRS.
- Total latency for N>0: out_valid rises N+2+Z_LAT cycles after the accept edge.

Test Plan:
- Bench detector stub Z(t)=A&B(t-Z_LAT), Z_LAT=1. in_word[7:0]=8'b11_01_11_00, in_pairs=4 -> det_clr_n low 1 cycle; A/B sequence 11,01,11,00; out_valid at cycle 7; out_hits=2, out_first=0.
- Same stub, in_word[7:0]=8'b00_00_01_11, in_pairs=4 -> out_hits=1, out_first=3. Rerun with all pairs 00 -> out_hits=0, out_first=all-ones.
- HIT_W=3, in_pairs=12, all pairs 11 -> out_hits=7 (saturated), out_first=0.
- in_pairs=0 -> out_valid at cycle 1, out_hits=0, no det_clr_n pulse, A/B stay 0. in_pairs=15 -> exactly 12 pairs streamed.
- Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> out_valid, out_hits and out_first stable; in_ready=0; second job accepted only the cycle after the out handshake.
- Assert clr during STREAM at pair 3 of 8 -> all outputs at reset values within the same cycle; no out_valid. A following job (in_pairs=2, pairs 11,11) -> out_hits=2.
